// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 SRAM access sequencer.
package slc3_mem_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned ADDR_HI_W = 4;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned STROBE_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } mem_state_t;

  typedef enum logic {
    CPU = 1'b0,
    DBG = 1'b1
  } req_id_t;

  // Active-low SRAM strobes, all deasserted.
  localparam logic [STROBE_W-1:0] STROBE_IDLE = 5'b11111;

  typedef struct packed {
    logic ce;
    logic ub;
    logic lb;
    logic oe;
    logic we;
  } strobe_t;

  // Access payload latched at grant.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester arbiter for the SRAM port.
// Build option: define SRAM_CPU_PRIORITY_EN for fixed CPU priority on ties;
// otherwise ties alternate against last_grant_i (round-robin).
module rr_arbiter2
  import slc3_mem_pkg::*;
(
  input  logic    cpu_req_i,
  input  logic    dbg_req_i,
  input  logic    en_i,
  input  req_id_t last_grant_i,
  output logic    gnt_valid_c,
  output req_id_t gnt_id_c
);

  // Pick a winner among the active requests.
  always_comb begin
    gnt_valid_c = en_i && (cpu_req_i || dbg_req_i);
    gnt_id_c    = CPU;
    if (cpu_req_i && dbg_req_i) begin
`ifdef SRAM_CPU_PRIORITY_EN
      gnt_id_c = CPU;
`else
      gnt_id_c = (last_grant_i == CPU) ? DBG : CPU;
`endif
    end else if (dbg_req_i) begin
      gnt_id_c = DBG;
    end
  end

`ifdef SRAM_CPU_PRIORITY_EN
  // Fixed priority ignores the grant history.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

endmodule

// File: rtl/sram_access_arbiter.sv
// SLC-3 SRAM access sequencer: shares one SRAM port between the CPU and a
// debug/loader port and generates fixed-timing active-low strobes.
// Build option: SRAM_CPU_PRIORITY_EN (see rr_arbiter2) selects fixed CPU priority.
module sram_access_arbiter
  import slc3_mem_pkg::*;
#(
  parameter int unsigned          WAIT_CYCLES = 2,
  parameter logic [ADDR_HI_W-1:0] ADDR_HI     = 4'h0
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        cpu_req,
  input  logic                        cpu_we,
  input  logic [ADDR_W-1:0]           cpu_addr,
  input  logic [DATA_W-1:0]           cpu_wdata,
  output logic                        cpu_ack,
  output logic [DATA_W-1:0]           cpu_rdata,
  input  logic                        dbg_req,
  input  logic                        dbg_we,
  input  logic [ADDR_W-1:0]           dbg_addr,
  input  logic [DATA_W-1:0]           dbg_wdata,
  output logic                        dbg_ack,
  output logic [DATA_W-1:0]           dbg_rdata,
  output logic                        busy,
  output logic                        Mem_CE,
  output logic                        Mem_UB,
  output logic                        Mem_LB,
  output logic                        Mem_OE,
  output logic                        Mem_WE,
  output logic [ADDR_HI_W+ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0]           Data_to_SRAM,
  input  logic [DATA_W-1:0]           Data_from_SRAM
);

  mem_state_t        state_q,      state_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  req_id_t           owner_q,      owner_d;
  req_id_t           last_grant_q, last_grant_d;
  mem_req_t          lat_q,        lat_d;
  strobe_t           strobe_q,     strobe_d;
  logic              cpu_ack_q,    cpu_ack_d;
  logic              dbg_ack_q,    dbg_ack_d;
  logic              busy_q,       busy_d;
  logic [DATA_W-1:0] cpu_rdata_q,  cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q,  dbg_rdata_d;

  logic    gnt_valid_c;
  req_id_t gnt_id_c;

  // Arbitration is only consulted while idle.
  rr_arbiter2 u_arb (
    .cpu_req_i    (cpu_req),
    .dbg_req_i    (dbg_req),
    .en_i         (state_q == IDLE),
    .last_grant_i (last_grant_q),
    .gnt_valid_c  (gnt_valid_c),
    .gnt_id_c     (gnt_id_c)
  );

  // State register and registered outputs; reset aborts any access in flight.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= CPU;
      last_grant_q <= DBG;
      lat_q        <= '0;
      strobe_q     <= strobe_t'(STROBE_IDLE);
      cpu_ack_q    <= 1'b0;
      dbg_ack_q    <= 1'b0;
      busy_q       <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      lat_q        <= lat_d;
      strobe_q     <= strobe_d;
      cpu_ack_q    <= cpu_ack_d;
      dbg_ack_q    <= dbg_ack_d;
      busy_q       <= busy_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  // Next-state, latches, read capture and next-cycle strobes/acks.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    lat_d        = lat_q;
    strobe_d     = strobe_t'(STROBE_IDLE);
    cpu_ack_d    = 1'b0;
    dbg_ack_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;

    case (state_q)
      IDLE: begin
        if (gnt_valid_c) begin
          state_d      = SETUP;
          owner_d      = gnt_id_c;
          last_grant_d = gnt_id_c;
          if (gnt_id_c == CPU) begin
            lat_d = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
          end else begin
            lat_d = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata};
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = CNT_W'(WAIT_CYCLES);
      end
      ACCESS: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = DONE;
          if (!lat_q.we) begin
            if (owner_q == CPU) cpu_rdata_d = Data_from_SRAM;
            else                dbg_rdata_d = Data_from_SRAM;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case (state_d)
      SETUP:   strobe_d = '{ce: 1'b0, ub: 1'b0, lb: 1'b0, oe: lat_d.we, we: 1'b1};
      ACCESS:  strobe_d = '{ce: 1'b0, ub: 1'b0, lb: 1'b0, oe: lat_d.we, we: ~lat_d.we};
      default: strobe_d = strobe_t'(STROBE_IDLE);
    endcase

    cpu_ack_d = (state_d == DONE) && (owner_d == CPU);
    dbg_ack_d = (state_d == DONE) && (owner_d == DBG);
    busy_d    = (state_d != IDLE);
  end

  assign cpu_ack      = cpu_ack_q;
  assign dbg_ack      = dbg_ack_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign dbg_rdata    = dbg_rdata_q;
  assign busy         = busy_q;
  assign Mem_CE       = strobe_q.ce;
  assign Mem_UB       = strobe_q.ub;
  assign Mem_LB       = strobe_q.lb;
  assign Mem_OE       = strobe_q.oe;
  assign Mem_WE       = strobe_q.we;
  assign ADDR         = {ADDR_HI, lat_q.addr};
  assign Data_to_SRAM = lat_q.wdata;

endmodule

// File: doc/sram_access_arbiter.md
Name: sram_access_arbiter

Overview:
- Sequences every SRAM access for the SLC-3 and shares the single SRAM port between two requesters: the CPU (the MAR/MDR path driven by the control FSM) and a debug/loader port (switch-driven memory inspect/load).
- Produces the active-low SRAM strobes, the 20-bit address and the write data toward the tristate interface, with a fixed, parameterised access timing.
- Returns read data and a single-cycle ack to the granted requester.

Parameters:
- WAIT_CYCLES, 2: number of cycles in the ACCESS state; legal range 1..15.
- ADDR_HI, 4'h0: upper 4 address bits prepended to the 16-bit address.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held high until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; sampled at grant.
- cpu_addr  in  16  CPU address (MAR); sampled at grant.
- cpu_wdata  in  16  CPU write data (MDR); sampled at grant.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  16  read data; valid with cpu_ack and held until the next CPU read ack.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata: same as the cpu_* ports, for the debug port.
- busy  out  1  high whenever the state is not IDLE.
- Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  active-low SRAM strobes.
- ADDR  out  20  {ADDR_HI, latched address}.
- Data_to_SRAM  out  16  latched write data.
- Data_from_SRAM  in  16  SRAM read data from the tristate buffer.

Behaviour:
- Reset (asynchronous, active-low), effective immediately:
  - state = IDLE; all five strobes = 1; ADDR = {ADDR_HI, 16'h0}; Data_to_SRAM = 0.
  - acks = 0; rdata outputs = 0; busy = 0; last_grant = DBG, so the CPU wins the first tie.
- Reset asserted mid-access aborts the access: no ack is issued and no write completes.
- State machine: IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
  - IDLE: if any request is high at a clock edge, grant it. The next state is SETUP, and addr, we, wdata and the grant owner are latched.
  - SETUP (1 cycle): CE = UB = LB = 0, ADDR is valid. For reads, OE = 0. WE = 1.
  - ACCESS (WAIT_CYCLES cycles, 4-bit down-counter):
    - Reads: OE = 0, and Data_from_SRAM is captured into the owner's rdata register on the last ACCESS cycle.
    - Writes: WE = 0 and OE = 1 throughout.
  - DONE (1 cycle): all strobes = 1, and the owner's ack = 1. The next state is always IDLE, so back-to-back requests see one idle cycle.
- Latency: request sampled in IDLE at edge N -> ack high during cycle N+WAIT_CYCLES+2.
- Arbitration (round-robin):
  - Only one requester high: it is granted.
  - Both high in IDLE: grant the requester that is not last_grant.
  - last_grant updates on every grant.
- Handshake:
  - A requester must hold req and its inputs until ack. Inputs are latched at grant, so later changes are ignored.
  - A req dropped before ack does not cancel the access; the ack is still pulsed.
  - A req still high in the cycle after ack is treated as a new request.
- Only the granted requester's ack may pulse. The other rdata register is untouched.
- ADDR and Data_to_SRAM are stable from SETUP through DONE. They hold their last value in IDLE.

Optional Feature:
- Macro: SRAM_CPU_PRIORITY_EN.
- Defined: fixed priority, CPU always wins a tie; last_grant is unused. The debug port can starve while the CPU requests continuously.
- Undefined (default): round-robin arbitration as specified above.

Decomposition:
- Package slc3_mem_pkg holds:
  - state enum mem_state_t {IDLE, SETUP, ACCESS, DONE}.
  - owner enum req_id_t {CPU, DBG}.
  - constant STROBE_IDLE = 5'b11111.
- One sub-module: rr_arbiter2. It takes two requests, an enable and last_grant, and returns a grant; the SRAM_CPU_PRIORITY_EN switch lives inside it.
- The top level holds the FSM, wait counter, latches and rdata registers.

Test Plan:
- Reset release, CPU read of 16'h0030 with SRAM model returning 16'hBEEF, WAIT_CYCLES=2 -> cpu_ack pulses exactly 4 cycles after req sampled; cpu_rdata = 16'hBEEF; OE low for 3 cycles; ADDR = 20'h00030.
- CPU write 16'h1234 to 16'h0040 -> WE low for exactly 2 cycles, OE high throughout, Data_to_SRAM = 16'h1234; the model reads back 16'h1234.
- cpu_req and dbg_req raised in the same cycle, both held, 3 rounds -> grant order CPU, DBG, CPU; one idle cycle between accesses. With SRAM_CPU_PRIORITY_EN defined -> CPU, CPU, CPU.
- dbg_req dropped one cycle after grant -> access completes; dbg_ack still pulses; cpu_ack stays 0.
- Reset asserted during ACCESS of a write -> strobes go to 1 immediately (async), no ack, state IDLE; the model location is unchanged.
- WAIT_CYCLES=1 and WAIT_CYCLES=15 builds -> ack latency of 3 and 17 cycles respectively.
